xadc_temp_poll: RTL and testbench
=================================

XADC_TEMP_POLL -- requirements
Module: xadc_temp_poll

Interface
REQ-001 Parameter POLL_CYCLES, default 100000, clock cycles between the starts of successive temperature reads (legal range 16..2^24).
REQ-002 Parameter TIMEOUT_CYCLES, default 64, maximum cycles to wait for drp_drdy after a request (legal range 2..255).
REQ-003 Parameter TEMP_ADDR, default 7'h00, DRP address of the on-die temperature status register.
REQ-004 Parameter ALARM_SET, default 2910, 12-bit code (about 85 C) at or above which alarm sets.
REQ-005 Parameter ALARM_CLEAR, default 2829, 12-bit code (about 75 C) below which alarm clears; ALARM_CLEAR < ALARM_SET.
REQ-006 clock  input  1  system clock; all logic on rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 drp_den  output  1  DRP enable, single-cycle pulse per read.
REQ-009 drp_dwe  output  1  DRP write enable, constant 0.
REQ-010 drp_daddr  output  7  DRP address, equals TEMP_ADDR while drp_den=1, 0 otherwise.
REQ-011 drp_di  output  16  DRP write data, constant 0.
REQ-012 drp_do  input  16  DRP read data, valid when drp_drdy=1.
REQ-013 drp_drdy  input  1  DRP read-complete strobe.
REQ-014 device_temp  output  12  latest temperature code, drp_do[15:4].
REQ-015 temp_valid  output  1  high once at least one read has succeeded since reset.
REQ-016 alarm  output  1  over-temperature / fail-safe alarm.
REQ-017 timeout_pulse  output  1  one-cycle pulse when a read times out.
REQ-018 err_count  output  8  saturating count of timeouts since reset.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT; IDLE -> REQ when the poll counter reaches 0; REQ -> WAIT unconditionally after one cycle; WAIT -> IDLE on drp_drdy or on timeout.
REQ-020 The poll counter SHALL load POLL_CYCLES-1 on entry to IDLE and decrement once per cycle in IDLE.
REQ-021 drp_den SHALL be 1 only in REQ, for exactly one cycle per read.
REQ-022 The wait counter SHALL clear on entry to WAIT and increment each WAIT cycle; timeout occurs when it equals TIMEOUT_CYCLES-1 with drp_drdy=0.
REQ-023 On drp_drdy in WAIT, device_temp SHALL load drp_do[15:4] at the same edge; temp_valid SHALL be set; the consecutive-timeout counter SHALL clear.
REQ-024 drp_drdy in IDLE or REQ SHALL be ignored (no state, data or counter change).
REQ-025 drp_drdy and timeout in the same WAIT cycle SHALL be treated as success.
REQ-026 On timeout, device_temp SHALL hold; timeout_pulse SHALL be 1 for one cycle; err_count SHALL increment, saturating at 255; the 2-bit consecutive-timeout counter SHALL increment, saturating at 3.
REQ-027 On a successful read, alarm SHALL be updated at the same edge from the new sample: set if sample >= ALARM_SET; cleared if sample < ALARM_CLEAR; otherwise held.
REQ-028 alarm SHALL be forced to 1 while the consecutive-timeout counter equals 3; the next successful read applies REQ-027.
REQ-029 All comparisons SHALL be unsigned on 12 bits.

Reset
REQ-030 While reset=1: state IDLE, poll counter reloaded, drp_den=0, drp_daddr=0, device_temp=12'hFFF, temp_valid=0, alarm=1, timeout_pulse=0, err_count=0, consecutive-timeout counter=0.
REQ-031 Reset asserted in REQ or WAIT SHALL abandon the read, and a subsequent drp_drdy SHALL be ignored under REQ-024.
REQ-032 The first drp_den after reset deassertion SHALL occur POLL_CYCLES cycles after the first cycle with reset=0.

Verification (POLL_CYCLES=16, TIMEOUT_CYCLES=8)
REQ-033 Release reset; DRP model returns 16'hA000 3 cycles after drp_den -> drp_den at cycle 16 with drp_daddr=0; device_temp=12'hA00; temp_valid=1; alarm=0.
REQ-034 Return 16'hB5E0 (2910) -> alarm=1; then 16'hB100 (2832) -> alarm stays 1; then 16'hB0C0 (2828) -> alarm=0.
REQ-035 Never assert drp_drdy -> timeout_pulse 8 cycles after drp_den; device_temp holds; alarm forced 1 after the 3rd timeout; err_count=3; a valid read of 16'h9000 clears alarm.
REQ-036 Assert drp_drdy with 16'h1230 in IDLE -> no change to device_temp, state or counters.
REQ-037 Assert reset in WAIT, then drp_drdy -> all outputs at reset values; the next drp_den is 16 cycles after release.
REQ-038 Force 300 timeouts -> err_count saturates at 255 with no wrap.

Source files
------------

// File: rtl/xadc_temp_poll_if.sv
// -----------------------------------------------------------------------------
// xadc_temp_poll_if
// Purpose : DRP (dynamic reconfiguration port) bundle between the temperature
//           poller and the XADC primitive. The poller only ever reads, so the
//           write path is present for completeness but held at zero.
// Signals :
//   drp_den   - enable, one-cycle pulse per access          (master -> slave)
//   drp_dwe   - write enable, always 0 from the poller       (master -> slave)
//   drp_daddr - 7-bit register address                       (master -> slave)
//   drp_di    - 16-bit write data, always 0 from the poller  (master -> slave)
//   drp_do    - 16-bit read data, valid with drp_drdy        (slave -> master)
//   drp_drdy  - read-complete strobe                         (slave -> master)
// -----------------------------------------------------------------------------
interface xadc_temp_poll_if;
    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        output drp_den,
        output drp_dwe,
        output drp_daddr,
        output drp_di,
        input  drp_do,
        input  drp_drdy
    );

    modport slave (
        input  drp_den,
        input  drp_dwe,
        input  drp_daddr,
        input  drp_di,
        output drp_do,
        output drp_drdy
    );
endinterface

// File: rtl/xadc_temp_poll.sv
// -----------------------------------------------------------------------------
// xadc_temp_poll
// Purpose : Periodically reads the XADC on-die temperature register over DRP,
//           keeps the latest 12-bit code, and drives an over-temperature alarm
//           with hysteresis. Repeated read failures are treated as unsafe and
//           force the alarm until a good sample arrives.
// Ports   :
//   clock           - system clock, rising edge
//   reset           - synchronous, active-high
//   drp             - DRP master side (see xadc_temp_poll_if)
//   device_temp_o   - latest temperature code (drp_do[15:4]), 12'hFFF after reset
//   temp_valid_o    - at least one read has succeeded since reset
//   alarm_o         - over-temperature / fail-safe alarm, 1 after reset
//   timeout_pulse_o - one-cycle pulse in the cycle a read times out
//   err_count_o     - saturating count of timeouts since reset
// -----------------------------------------------------------------------------
module xadc_temp_poll #(
    parameter int unsigned POLL_CYCLES    = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [6:0]  TEMP_ADDR      = 7'h00,
    parameter logic [11:0] ALARM_SET      = 12'd2910,
    parameter logic [11:0] ALARM_CLEAR    = 12'd2829
) (
    input  logic                    clock,
    input  logic                    reset,
    xadc_temp_poll_if.master        drp,
    output logic [11:0]             device_temp_o,
    output logic                    temp_valid_o,
    output logic                    alarm_o,
    output logic                    timeout_pulse_o,
    output logic [7:0]              err_count_o
);

    // POLL_CYCLES is at most 2^24, so its reload value always fits 24 bits.
    localparam logic [23:0] POLL_RELOAD  = 24'(POLL_CYCLES - 32'd1);
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Saturating increment of the 8-bit error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Saturating increment of the 2-bit consecutive-timeout counter.
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        if (v == 2'd3) begin
            return v;
        end else begin
            return v + 2'd1;
        end
    endfunction

    state_t      state_q,  state_d;
    logic [23:0] poll_q,   poll_d;
    logic [7:0]  wait_q,   wait_d;
    logic        den_q,    den_d;
    logic [6:0]  daddr_q,  daddr_d;
    logic [11:0] temp_q,   temp_d;
    logic        valid_q,  valid_d;
    logic        alarm_q,  alarm_d;
    logic [7:0]  err_q,    err_d;
    logic [1:0]  consec_q, consec_d;

    logic        timeout_s;
    logic [11:0] sample_s;
    logic [1:0]  consec_inc_s;
    logic        unused_s;

    assign sample_s     = drp.drp_do[15:4];
    assign consec_inc_s = sat_inc2(consec_q);
    // The low nibble of the status register carries no temperature information.
    assign unused_s     = ^drp.drp_do[3:0];

    // Next-state, counter and result logic for the poll / request / wait cycle.
    always_comb begin
        state_d   = state_q;
        poll_d    = poll_q;
        wait_d    = wait_q;
        temp_d    = temp_q;
        valid_d   = valid_q;
        alarm_d   = alarm_q;
        err_d     = err_q;
        consec_d  = consec_q;
        timeout_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // drp_drdy is deliberately not looked at here: a stray or late
                // strobe must not disturb the sample or the counters.
                if (poll_q == 24'd0) begin
                    state_d = ST_REQ;
                end else begin
                    poll_d = poll_q - 24'd1;
                end
            end

            ST_REQ: begin
                state_d = ST_WAIT;
                wait_d  = 8'd0;
            end

            ST_WAIT: begin
                // A strobe arriving in the last allowed cycle still wins over
                // the timeout, so it is tested first.
                if (drp.drp_drdy) begin
                    state_d  = ST_IDLE;
                    poll_d   = POLL_RELOAD;
                    temp_d   = sample_s;
                    valid_d  = 1'b1;
                    consec_d = 2'd0;
                    if (sample_s >= ALARM_SET) begin
                        alarm_d = 1'b1;
                    end else if (sample_s < ALARM_CLEAR) begin
                        alarm_d = 1'b0;
                    end else begin
                        alarm_d = alarm_q;
                    end
                end else if (wait_q == TIMEOUT_LAST) begin
                    state_d   = ST_IDLE;
                    poll_d    = POLL_RELOAD;
                    timeout_s = 1'b1;
                    err_d     = sat_inc8(err_q);
                    consec_d  = consec_inc_s;
                    // Three failures in a row: assume the worst until a good read.
                    if (consec_inc_s == 2'd3) begin
                        alarm_d = 1'b1;
                    end else begin
                        alarm_d = alarm_q;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                poll_d  = POLL_RELOAD;
            end
        endcase
    end

    // DRP strobe and address are registered off the next state so that they
    // line up exactly with the single REQ cycle.
    always_comb begin
        den_d = (state_d == ST_REQ);
        if (den_d) begin
            daddr_d = TEMP_ADDR;
        end else begin
            daddr_d = 7'h00;
        end
    end

    // State and datapath registers; reset abandons any read in flight and
    // starts from the fail-safe view (alarm on, temperature unknown).
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            poll_q   <= POLL_RELOAD;
            wait_q   <= 8'd0;
            den_q    <= 1'b0;
            daddr_q  <= 7'h00;
            temp_q   <= 12'hFFF;
            valid_q  <= 1'b0;
            alarm_q  <= 1'b1;
            err_q    <= 8'd0;
            consec_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            poll_q   <= poll_d;
            wait_q   <= wait_d;
            den_q    <= den_d;
            daddr_q  <= daddr_d;
            temp_q   <= temp_d;
            valid_q  <= valid_d;
            alarm_q  <= alarm_d;
            err_q    <= err_d;
            consec_q <= consec_d;
        end
    end

    assign drp.drp_den   = den_q;
    assign drp.drp_dwe   = 1'b0;
    assign drp.drp_daddr = daddr_q;
    assign drp.drp_di    = 16'h0000;

    assign device_temp_o = temp_q;
    assign temp_valid_o  = valid_q;
    assign alarm_o       = alarm_q;
    assign err_count_o   = err_q;
    // The pulse marks the cycle in which the timeout is decided; reset masks it.
    assign timeout_pulse_o = timeout_s & ~reset;

endmodule

// File: tb/tb_xadc_temp_poll.sv
module tb_xadc_temp_poll;

    localparam int          POLL = 16;
    localparam int          TMO  = 8;
    localparam logic [6:0]  ADDR = 7'h13;
    localparam int          SET  = 2910;
    localparam int          CLR  = 2829;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] device_temp;
    logic        temp_valid;
    logic        alarm;
    logic        timeout_pulse;
    logic [7:0]  err_count;

    xadc_temp_poll_if drp_if ();

    xadc_temp_poll #(
        .POLL_CYCLES    (POLL),
        .TIMEOUT_CYCLES (TMO),
        .TEMP_ADDR      (ADDR)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .drp             (drp_if),
        .device_temp_o   (device_temp),
        .temp_valid_o    (temp_valid),
        .alarm_o         (alarm),
        .timeout_pulse_o (timeout_pulse),
        .err_count_o     (err_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int next_den = 0;

    // Reference model: result of each read as the requirements state it.
    int m_temp;
    int m_valid;
    int m_alarm;
    int m_err;
    int m_consec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        m_temp = 12'hFFF; m_valid = 0; m_alarm = 1; m_err = 0; m_consec = 0;
    endtask

    task automatic model_success(input logic [15:0] d);
        m_temp   = int'(d[15:4]);
        m_valid  = 1;
        m_consec = 0;
        if (m_temp >= SET) m_alarm = 1;
        else if (m_temp < CLR) m_alarm = 0;
    endtask

    task automatic model_timeout();
        if (m_err < 255) m_err++;
        if (m_consec < 3) m_consec++;
        if (m_consec == 3) m_alarm = 1;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_temp"},  32'(device_temp), 32'(m_temp));
        chk({tag, "_valid"}, 32'(temp_valid),  32'(m_valid));
        chk({tag, "_alarm"}, 32'(alarm),       32'(m_alarm));
        chk({tag, "_err"},   32'(err_count),   32'(m_err));
        chk({tag, "_dwe"},   32'(drp_if.drp_dwe), 32'(0));
        chk({tag, "_di"},    32'(drp_if.drp_di),  32'(0));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_den"},   32'(drp_if.drp_den),   32'(0));
        chk({tag, "_daddr"}, 32'(drp_if.drp_daddr), 32'(0));
        chk({tag, "_pulse"}, 32'(timeout_pulse),    32'(0));
        check_outs(tag);
    endtask

    // Wait (bounded) for drp_den; optionally throw a stray strobe into IDLE.
    task automatic wait_den(input bit inject);
        int guard;
        guard = 0;
        while (drp_if.drp_den !== 1'b1 && guard < 64) begin
            if (inject && cyc == next_den - 5) begin
                drp_if.drp_drdy = 1'b1;
                drp_if.drp_do   = 16'h1230;
            end else begin
                drp_if.drp_drdy = 1'b0;
            end
            tick();
            guard++;
        end
        drp_if.drp_drdy = 1'b0;
        chk("den_seen",  32'(drp_if.drp_den),   32'(1));
        chk("den_cycle", 32'(cyc),              32'(next_den));
        chk("den_addr",  32'(drp_if.drp_daddr), 32'(ADDR));
        check_outs("at_den");
    endtask

    // One complete read: response after lat cycles (lat > TMO means none).
    task automatic read_txn(input int lat, input logic [15:0] data, input bit inject);
        int e;
        wait_den(inject);
        e = cyc + TMO;
        for (int k = 1; k <= TMO; k++) begin
            tick();
            if (k == 1) begin
                chk("den_single", 32'(drp_if.drp_den),   32'(0));
                chk("addr_zero",  32'(drp_if.drp_daddr), 32'(0));
            end
            if (k == lat) begin
                drp_if.drp_drdy = 1'b1;
                drp_if.drp_do   = data;
            end
            #1;
            chk("tmo_pulse", 32'(timeout_pulse), 32'(k == TMO && lat > TMO));
            if (k == lat || k == TMO) begin
                e = cyc;
                break;
            end
        end
        if (lat <= TMO) model_success(data);
        else model_timeout();
        tick();
        drp_if.drp_drdy = 1'b0;
        drp_if.drp_do   = 16'(($urandom));
        chk("pulse_after", 32'(timeout_pulse), 32'(0));
        check_outs("after_read");
        next_den = e + 1 + POLL;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drp_if.drp_drdy = 1'b0;
        repeat (3) tick();
        model_reset();
        check_reset_vals("reset");
        reset = 1'b0;
        cyc = 0;
        next_den = POLL;
    endtask

    initial begin
        logic [11:0] code;
        reset = 1'b1;
        drp_if.drp_drdy = 1'b0;
        drp_if.drp_do   = 16'h0000;
        model_reset();

        // Reset state and first read.
        apply_reset();
        read_txn(3, 16'hA000, 1'b0);

        // Hysteresis thresholds.
        read_txn(3, 16'hB5E0, 1'b0);
        read_txn(3, 16'hB100, 1'b0);
        read_txn(3, 16'hB0C0, 1'b0);

        // Three consecutive timeouts force the alarm; a good read clears it.
        repeat (3) read_txn(99, 16'h0000, 1'b0);
        chk("err_three", 32'(err_count), 32'(3));
        chk("alarm_forced", 32'(alarm), 32'(1));
        read_txn(2, 16'h9000, 1'b0);
        chk("alarm_cleared", 32'(alarm), 32'(0));

        // Stray strobe in IDLE is ignored; strobe on the last wait cycle wins.
        read_txn(4, 16'h5550, 1'b1);
        read_txn(TMO, 16'hB800, 1'b0);

        // Reset in WAIT, strobe during and just after reset.
        wait_den(1'b0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        drp_if.drp_drdy = 1'b1;
        drp_if.drp_do   = 16'hA5A0;
        #1;
        model_reset();
        check_reset_vals("reset_wait");
        tick();
        reset = 1'b0;
        cyc = 0;
        next_den = POLL;
        tick();
        drp_if.drp_drdy = 1'b0;
        read_txn(3, 16'h7770, 1'b0);

        // Randomized reads concentrated around the alarm thresholds.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) code = 12'($urandom_range(2800, 2940));
            else code = 12'($urandom_range(0, 4095));
            read_txn(int'($urandom_range(1, 11)), {code, 4'($urandom)}, 1'($urandom_range(0, 1)));
        end

        // Error counter saturation.
        repeat (300) read_txn(99, 16'h0000, 1'b0);
        chk("err_saturated", 32'(err_count), 32'(255));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
